// File: rtl/mem_wb_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe_pkg
// Shared definitions for the MEM/WB pipeline register slice:
//   - default stall bus width
//   - zero-word / zero-address constants (sliced to width by users)
//   - false/true constants
//   - the per-cycle action type and the priority decoder that picks it
// -----------------------------------------------------------------------------
package mem_wb_pipe_pkg;

    localparam int STALL_W_DEF = 7;

    // Widest data/address any instance may use; users slice [W-1:0].
    localparam int MAX_W = 256;
    localparam logic [MAX_W-1:0] ZERO_WORD = '0;
    localparam logic [MAX_W-1:0] ZERO_ADDR = '0;

    localparam logic FALSE = 1'b0;
    localparam logic TRUE  = 1'b1;

    // Exactly one action is taken per clock (reset is handled by the flops).
    typedef enum logic [2:0] {
        ACT_FREEZE,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_ADVANCE,
        ACT_HOLD
    } action_e;

    // Priority: freeze > flush > bubble > advance > hold.
    function automatic action_e pick_action(
        input logic rdy,
        input logic flush,
        input logic stall_here,
        input logic stall_next
    );
        if (!rdy)             return ACT_FREEZE;
        else if (flush)       return ACT_FLUSH;
        else if (!stall_here) return ACT_ADVANCE;
        else if (!stall_next) return ACT_BUBBLE;
        else                  return ACT_HOLD;
    endfunction

endpackage

// File: rtl/mem_wb_pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset, clears the count
//   en    - counting enable (low freezes the count)
//   inc   - increment request for this cycle
//   cnt_o - current count
// -----------------------------------------------------------------------------
module sat_counter
    import mem_wb_pipe_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          inc,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (en && inc && (cnt_q != {CW{TRUE}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe
// MEM/WB pipeline register with per-port write-back enables, bubble/flush
// insertion, hold on downstream stall, global freeze, and two saturating
// performance counters.
// Ports:
//   clk, rst             - clock; asynchronous active-low reset
//   rdy                  - global ready, low freezes every register
//   stall[STALL_W-1:0]   - stall bus; only bits STAGE and STAGE+1 matter
//   flush                - replace the entry captured this cycle by a bubble
//   in_valid, in_we,
//   in_waddr, in_wdata   - upstream entry; port p at [p*AW +: AW] / [p*DW +: DW]
//   valid_o, we_o,
//   waddr_o, wdata_o     - registered entry
//   bubble_cnt_o         - bubbles inserted (saturating)
//   retire_cnt_o         - valid entries captured (saturating)
// -----------------------------------------------------------------------------
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NPORT   = 1,
    parameter int STALL_W = STALL_W_DEF,
    parameter int STAGE   = 5,
    parameter int CW      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [NPORT-1:0]      in_we,
    input  logic [NPORT*AW-1:0]   in_waddr,
    input  logic [NPORT*DW-1:0]   in_wdata,
    output logic                  valid_o,
    output logic [NPORT-1:0]      we_o,
    output logic [NPORT*AW-1:0]   waddr_o,
    output logic [NPORT*DW-1:0]   wdata_o,
    output logic [CW-1:0]         bubble_cnt_o,
    output logic [CW-1:0]         retire_cnt_o
);

    action_e action;
    assign action = pick_action(rdy, flush, stall[STAGE], stall[STAGE+1]);

    // Only two stall bits steer this stage; the rest are deliberately ignored.
    logic unused_stall;
    assign unused_stall = ^stall;

    // Per-port write enable as it would be captured on an advance.
    logic [NPORT-1:0] port_en;
    logic [NPORT-1:0] adv_we;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [AW-1:0] addr_p;
        logic          we_win;

        assign addr_p     = in_waddr[p*AW +: AW];
        // Writes to address zero are discarded (hard-wired zero register).
        assign port_en[p] = in_valid & in_we[p] & (addr_p != ZERO_ADDR[AW-1:0]);

        // A higher-index port writing the same address wins the conflict.
        always_comb begin
            we_win = port_en[p];
            for (int q = p + 1; q < NPORT; q++) begin
                if (port_en[q] && (in_waddr[q*AW +: AW] == addr_p)) begin
                    we_win = FALSE;
                end
            end
        end

        assign adv_we[p] = we_win;
    end

    logic                valid_d, valid_q;
    logic [NPORT-1:0]    we_d,    we_q;
    logic [NPORT*AW-1:0] waddr_d, waddr_q;
    logic [NPORT*DW-1:0] wdata_d, wdata_q;

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (action)
            ACT_FLUSH, ACT_BUBBLE: begin
                valid_d = FALSE;
                we_d    = '0;
                waddr_d = {NPORT{ZERO_ADDR[AW-1:0]}};
                wdata_d = {NPORT{ZERO_WORD[DW-1:0]}};
            end
            ACT_ADVANCE: begin
                // Address and data are copied unmasked; only enables gate.
                valid_d = in_valid;
                we_d    = adv_we;
                waddr_d = in_waddr;
                wdata_d = in_wdata;
            end
            default: begin
                // Freeze and hold keep the current entry.
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= FALSE;
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign valid_o = valid_q;
    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

    logic bubble_inc;
    logic retire_inc;
    assign bubble_inc = (action == ACT_BUBBLE);
    assign retire_inc = (action == ACT_ADVANCE) && in_valid;

    sat_counter #(.CW(CW)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .inc   (bubble_inc),
        .cnt_o (bubble_cnt_o)
    );

    sat_counter #(.CW(CW)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .inc   (retire_inc),
        .cnt_o (retire_cnt_o)
    );

endmodule

// File: tb/tb_mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_pipe
// Two instances share control inputs: dut_a uses default parameters
// (NPORT=1, CW=32) on port 0 of the stimulus; dut_b uses NPORT=2, CW=4.
// A behavioural model of the write-back register tracks both.
// -----------------------------------------------------------------------------
module tb_mem_wb_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rdy;
    logic [6:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [1:0]  in_we;
    logic [9:0]  in_waddr;
    logic [63:0] in_wdata;

    logic        valid_a;
    logic [0:0]  we_a;
    logic [4:0]  waddr_a;
    logic [31:0] wdata_a;
    logic [31:0] bub_a, ret_a;

    logic        valid_b;
    logic [1:0]  we_b;
    logic [9:0]  waddr_b;
    logic [63:0] wdata_b;
    logic [3:0]  bub_b, ret_b;

    mem_wb_pipe dut_a (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_we        (in_we[0:0]),
        .in_waddr     (in_waddr[4:0]),
        .in_wdata     (in_wdata[31:0]),
        .valid_o      (valid_a),
        .we_o         (we_a),
        .waddr_o      (waddr_a),
        .wdata_o      (wdata_a),
        .bubble_cnt_o (bub_a),
        .retire_cnt_o (ret_a)
    );

    mem_wb_pipe #(.NPORT(2), .CW(4)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_we        (in_we),
        .in_waddr     (in_waddr),
        .in_wdata     (in_wdata),
        .valid_o      (valid_b),
        .we_o         (we_b),
        .waddr_o      (waddr_b),
        .wdata_o      (wdata_b),
        .bubble_cnt_o (bub_b),
        .retire_cnt_o (ret_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic            m_valid;
    logic            m_we_a;
    logic [1:0]      m_we_b;
    logic [4:0]      m_addr [2];
    logic [31:0]     m_data [2];
    longint unsigned m_bub_a, m_ret_a, m_bub_b, m_ret_b;

    localparam longint unsigned MAX_A = 64'hFFFF_FFFF;
    localparam longint unsigned MAX_B = 64'd15;

    function automatic longint unsigned sat_inc(input longint unsigned v,
                                                input longint unsigned max);
        return (v >= max) ? max : v + 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_we_a  = 1'b0;
        m_we_b  = 2'b00;
        m_addr  = '{default: '0};
        m_data  = '{default: '0};
        m_bub_a = 0;
        m_ret_a = 0;
        m_bub_b = 0;
        m_ret_b = 0;
    endtask

    // Next entry from the current inputs, following the action rules.
    task automatic model_step();
        logic [4:0] a [2];
        logic       en [2];
        if (!rdy) return;
        if (flush || stall[5]) begin
            if (!flush && stall[6]) return;          // hold
            m_valid = 1'b0;
            m_we_a  = 1'b0;
            m_we_b  = 2'b00;
            m_addr  = '{default: '0};
            m_data  = '{default: '0};
            if (!flush) begin
                m_bub_a = sat_inc(m_bub_a, MAX_A);
                m_bub_b = sat_inc(m_bub_b, MAX_B);
            end
            return;
        end
        a[0] = in_waddr[4:0];
        a[1] = in_waddr[9:5];
        for (int p = 0; p < 2; p++) en[p] = in_valid && in_we[p] && (a[p] != 0);
        m_we_a    = en[0];
        m_we_b[1] = en[1];
        m_we_b[0] = en[0] && !(en[1] && (a[1] == a[0]));
        m_valid   = in_valid;
        m_addr    = a;
        m_data[0] = in_wdata[31:0];
        m_data[1] = in_wdata[63:32];
        if (in_valid) begin
            m_ret_a = sat_inc(m_ret_a, MAX_A);
            m_ret_b = sat_inc(m_ret_b, MAX_B);
        end
    endtask

    task automatic compare_all(input string step);
        check({step, ".valid_a"}, 64'(valid_a), 64'(m_valid));
        check({step, ".we_a"},    64'(we_a),    64'(m_we_a));
        check({step, ".waddr_a"}, 64'(waddr_a), 64'(m_addr[0]));
        check({step, ".wdata_a"}, 64'(wdata_a), 64'(m_data[0]));
        check({step, ".bub_a"},   64'(bub_a),   m_bub_a);
        check({step, ".ret_a"},   64'(ret_a),   m_ret_a);
        check({step, ".valid_b"}, 64'(valid_b), 64'(m_valid));
        check({step, ".we_b"},    64'(we_b),    64'(m_we_b));
        check({step, ".waddr_b"}, 64'(waddr_b), 64'({m_addr[1], m_addr[0]}));
        check({step, ".wdata_b"}, 64'(wdata_b), {m_data[1], m_data[0]});
        check({step, ".bub_b"},   64'(bub_b),   m_bub_b);
        check({step, ".ret_b"},   64'(ret_b),   m_ret_b);
    endtask

    // Inputs change #1 after a rising edge; outputs are sampled at the same point.
    task automatic cycle(input string step);
        model_step();
        @(posedge clk);
        #1;
        compare_all(step);
    endtask

    task automatic set_port(input int p, input logic we, input logic [4:0] addr,
                            input logic [31:0] data);
        in_we[p]            = we;
        in_waddr[p*5 +: 5]  = addr;
        in_wdata[p*32 +: 32] = data;
    endtask

    // Reset asserted between edges; outputs must clear before any edge.
    task automatic do_reset(input string step);
        rst = 1'b0;
        #1;
        model_reset();
        compare_all(step);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        rdy      = 1'b1;
        stall    = '0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_we    = '0;
        in_waddr = '0;
        in_wdata = '0;
        #2;
        model_reset();
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Advance: one-cycle latency capture.
        in_valid = 1'b1;
        set_port(0, 1'b1, 5'd3, 32'hDEAD_BEEF);
        set_port(1, 1'b0, 5'd0, 32'h0);
        cycle("adv");
        check("adv.we_const",    64'(we_a),    64'd1);
        check("adv.waddr_const", 64'(waddr_a), 64'd3);
        check("adv.wdata_const", 64'(wdata_a), 64'hDEAD_BEEF);
        check("adv.ret_const",   64'(ret_a),   64'd1);

        // Bubble for one cycle, then hold for three.
        stall = 7'b010_0000;
        cycle("bubble");
        check("bubble.valid_const", 64'(valid_a), 64'd0);
        check("bubble.cnt_const",   64'(bub_a),   64'd1);
        stall = 7'b110_0000;
        for (int i = 0; i < 3; i++) cycle("hold");
        check("hold.cnt_const", 64'(bub_a), 64'd1);

        // Zero-address drop and same-address conflict.
        stall = '0;
        set_port(0, 1'b1, 5'd0, 32'h1111_1111);
        set_port(1, 1'b1, 5'd7, 32'h2222_2222);
        cycle("zero_addr");
        check("zero_addr.we_b_const", 64'(we_b), 64'b10);
        set_port(0, 1'b1, 5'd9, 32'h3333_3333);
        set_port(1, 1'b1, 5'd9, 32'h4444_4444);
        cycle("conflict");
        check("conflict.we_b_const", 64'(we_b), 64'b10);
        check("conflict.we_a_const", 64'(we_a), 64'd1);

        // Freeze with new inputs, then flush.
        rdy = 1'b0;
        set_port(0, 1'b1, 5'd4, 32'h5555_5555);
        set_port(1, 1'b1, 5'd5, 32'h6666_6666);
        stall = 7'b010_0000;
        cycle("freeze");
        check("freeze.waddr_b_const", 64'(waddr_b), 64'({5'd9, 5'd9}));
        rdy   = 1'b1;
        flush = 1'b1;
        stall = '0;
        cycle("flush");
        check("flush.valid_const", 64'(valid_b), 64'd0);
        check("flush.bub_const",   64'(bub_a),   64'd1);
        flush = 1'b0;

        // Async reset while an entry is held.
        set_port(0, 1'b1, 5'd6, 32'h1234_5678);
        set_port(1, 1'b1, 5'd8, 32'h8765_4321);
        cycle("pre_hold");
        stall = 7'b110_0000;
        cycle("held");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        check("async_rst.valid_const", 64'(valid_b), 64'd0);
        @(negedge clk);
        rst   = 1'b1;
        stall = 7'b110_0000;
        cycle("post_rst_hold");
        stall = '0;
        cycle("post_rst_adv");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            rdy      = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            stall    = 7'($urandom);
            in_valid = 1'($urandom);
            set_port(0, 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            set_port(1, 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            cycle("rand");
        end

        // Saturation of the 4-bit retire counter.
        rdy   = 1'b1;
        flush = 1'b0;
        stall = '0;
        do_reset("reset2");
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) cycle("sat");
        check("sat.ret_b_const", 64'(ret_b), 64'd15);
        check("sat.ret_a_const", 64'(ret_a), 64'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL provide parameter DW, default 32, write-back data width per port.
REQ-002 SHALL provide parameter AW, default 5, register address width per port.
REQ-003 SHALL provide parameter NPORT, default 1, number of write-back ports; legal range 1..4.
REQ-004 SHALL provide parameter STALL_W, default 7, stall bus width.
REQ-005 SHALL provide parameter STAGE, default 5, index of this stage's stall bit; legal range 0..STALL_W-2.
REQ-006 SHALL provide parameter CW, default 32, performance counter width.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 rdy  input  1  global ready; low freezes all state.
REQ-010 stall  input  STALL_W  pipeline stall bus.
REQ-011 flush  input  1  kill the entry being captured this cycle.
REQ-012 in_valid  input  1  upstream entry valid.
REQ-013 in_we  input  NPORT  per-port write enable.
REQ-014 in_waddr  input  NPORT*AW  per-port destination, port p at bits [p*AW +: AW].
REQ-015 in_wdata  input  NPORT*DW  per-port data, port p at bits [p*DW +: DW].
REQ-016 valid_o  output  1  registered entry valid.
REQ-017 we_o  output  NPORT  registered write enables.
REQ-018 waddr_o  output  NPORT*AW  registered destinations.
REQ-019 wdata_o  output  NPORT*DW  registered data.
REQ-020 bubble_cnt_o  output  CW  bubbles inserted, saturating.
REQ-021 retire_cnt_o  output  CW  valid entries captured, saturating.

Function
REQ-022 Each cycle SHALL select exactly one action, in priority order: reset, freeze (rdy low), flush, bubble, advance, hold.
REQ-023 Freeze SHALL hold every register, counters included.
REQ-024 Flush (rdy high, flush high) SHALL load a bubble (valid_o, we_o, waddr_o, wdata_o all zero), regardless of stall, and SHALL NOT increment bubble_cnt_o.
REQ-025 Bubble (stall[STAGE]=1, stall[STAGE+1]=0) SHALL load zeros as in REQ-024 and increment bubble_cnt_o.
REQ-026 Advance (stall[STAGE]=0) SHALL capture inputs with one-cycle latency: valid_o<=in_valid; per port we_o[p]<=in_valid & in_we[p] & (in_waddr[p]!=0), subject to REQ-027; address and data copied unmasked.
REQ-027 If two enabled ports target the same nonzero address in one cycle, the higher-index port SHALL win and the lower port's we_o bit SHALL be cleared.
REQ-028 Hold (stall[STAGE]=1, stall[STAGE+1]=1) SHALL keep all outputs and counters.
REQ-029 retire_cnt_o SHALL increment by 1 on each advance with in_valid=1, independent of write enables.
REQ-030 Counters SHALL saturate at 2^CW-1 and never wrap.
REQ-031 Stall bits other than STAGE and STAGE+1 SHALL have no effect.

Reset
REQ-032 rst low SHALL asynchronously clear valid_o, we_o, waddr_o, wdata_o, bubble_cnt_o and retire_cnt_o to zero, independent of clk and rdy.
REQ-033 Reset asserted mid-stall SHALL discard the held entry; the first edge after release SHALL apply REQ-022 normally.

Structure
REQ-034 Stall bus width, zero-word and zero-address constants, and the false/true constants SHALL come from the shared defines file.
REQ-035 The saturating counter SHALL be one sub-module, sat_counter (parameter CW; inputs clk, rst, en, inc), instantiated twice.
REQ-036 Per-port logic SHALL be a generate loop over NPORT; no per-port code duplication.

Verification
REQ-037 Advance: NPORT=1, in_valid=1, in_we=1, in_waddr=3, in_wdata=0xDEADBEEF, stall=0 -> next cycle we_o=1, waddr_o=3, wdata_o=0xDEADBEEF, retire_cnt_o=1.
REQ-038 Bubble/hold: stall[5]=1, stall[6]=0 for one cycle, then stall[6:5]=2'b11 for three cycles -> outputs zero from the first edge; bubble_cnt_o=1 and unchanged through the hold.
REQ-039 Zero-address and conflict: NPORT=2, ports (we=1, addr=0) and (we=1, addr=7) -> we_o=2'b10; then both ports addr=9 -> we_o=2'b10.
REQ-040 Freeze and flush: rdy=0 with new inputs -> outputs and counters unchanged; rdy=1, flush=1, stall=0 -> bubble, bubble_cnt_o unchanged.
REQ-041 Saturation: CW=4, 20 advances with in_valid=1 -> retire_cnt_o stops at 15.
REQ-042 Async reset: rst pulsed low between clock edges while an entry is held -> all outputs zero immediately, before the next edge.
